maxpool: RTL

MAXPOOL -- requirements
Module: maxpool

---
 rtl/maxpool.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/maxpool.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | maxpool : 2x2 stride-2 signed max pooling between BRAMs   | Rev 1.0      |
// +--------------------------------------------------------------------------+
module maxpool #(
    parameter int          IN_W     = 26,
    parameter int          IN_H     = 26,
    parameter logic [31:0] SRC_BASE = 32'd0,
    parameter logic [31:0] DST_BASE = 32'd0,
    parameter int          RELU     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        finish,
    output logic        S_R_req,
    output logic [31:0] S_addr,
    input  logic [31:0] S_R_data,
    output logic [31:0] D_addr,
    output logic [3:0]  D_W_req,
    output logic [31:0] D_W_data
);

    localparam int          OUT_W  = IN_W / 2;
    localparam int          OUT_H  = IN_H / 2;
    localparam bit          EMPTY  = (OUT_W == 0) || (OUT_H == 0);
    localparam logic [15:0] LAST_J = 16'(OUT_W - 1);
    localparam logic [15:0] LAST_I = 16'(OUT_H - 1);
    localparam logic [31:0] IN_W_L  = 32'(IN_W);
    localparam logic [31:0] OUT_W_L = 32'(OUT_W);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [15:0]        i;
    logic [15:0]        j;
    logic [1:0]         k;
    logic signed [31:0] run_max;

    logic [31:0] src_row;
    logic [31:0] src_col;
    logic [31:0] src_idx;
    logic [31:0] dst_idx;
    logic        last_pix;

    // k[1] selects the lower source row of the window, k[0] the right column
    assign src_row  = {15'd0, i, k[1]};
    assign src_col  = {15'd0, j, k[0]};
    assign src_idx  = src_row * IN_W_L + src_col;
    assign dst_idx  = {16'd0, i} * OUT_W_L + {16'd0, j};
    assign last_pix = (i == LAST_I) && (j == LAST_J);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        finish   = 1'b0;
        S_R_req  = 1'b0;
        S_addr   = '0;
        D_W_req  = '0;
        D_addr   = '0;
        D_W_data = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (EMPTY) state_nx = DONE;
                    else       state_nx = READ;
                end
            end
            READ: begin
                S_R_req = 1'b1;
                S_addr  = SRC_BASE + (src_idx << 2);
                if (k == 2'd3) state_nx = DRAIN;
            end
            DRAIN: state_nx = WRITE;
            WRITE: begin
                D_W_req  = 4'hF;
                D_addr   = DST_BASE + (dst_idx << 2);
                D_W_data = (RELU != 0 && run_max[31]) ? '0 : run_max;
                if (last_pix) state_nx = DONE;
                else          state_nx = READ;
            end
            DONE: begin
                finish = 1'b1;
                if (start) begin
                    if (EMPTY) state_nx = DONE;
                    else       state_nx = READ;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Read data lags the request by one cycle: word k arrives while k+1 is issued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i       <= '0;
            j       <= '0;
            k       <= '0;
            run_max <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        i <= '0;
                        j <= '0;
                        k <= '0;
                    end
                end
                READ: begin
                    k <= k + 2'd1;
                    if (k == 2'd1) begin
                        run_max <= $signed(S_R_data);
                    end else if (k != 2'd0 && $signed(S_R_data) > run_max) begin
                        run_max <= $signed(S_R_data);
                    end
                end
                DRAIN: begin
                    if ($signed(S_R_data) > run_max) run_max <= $signed(S_R_data);
                end
                WRITE: begin
                    if (j == LAST_J) begin
                        j <= '0;
                        i <= i + 16'd1;
                    end else begin
                        j <= j + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
